gpio_ctrl: RTL
==============

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, number of GPIO pins (range 1..32).
REQ-002 Port: clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 Port: req_i  in  1  register access request; held high until ack_o.
REQ-005 Port: we_i  in  1  1 = write, 0 = read; stable while req_i is high.
REQ-006 Port: addr_i  in  3  register index; stable while req_i is high.
REQ-007 Port: wdata_i  in  32  write data; stable while req_i is high.
REQ-008 Port: ack_o  out  1  one-cycle access completion pulse.
REQ-009 Port: rdata_o  out  32  read data, valid only while ack_o is high, 0 otherwise.
REQ-010 Port: in_pad_i  in  WIDTH  raw asynchronous pad input levels.
REQ-011 Port: out_pad_o  out  WIDTH  pad output data.
REQ-012 Port: oen_padoe_o  out  WIDTH  per-pin output enable, 1 = drive.
REQ-013 Port: irq_o  out  1  registered level interrupt.

Function
REQ-014 Register map (unused upper bits read 0, ignore writes): 0 OUT RW; 1 OE RW; 2 IN RO (synchronised pads); 3 INTE RW; 4 PTRIG RW (1 = rising, 0 = falling); 5 INTS read / write-1-to-clear; 6 CTRL RW, bit0 = global IE; 7 unmapped.
REQ-015 out_pad_o and oen_padoe_o shall be driven directly from the OUT and OE registers.
REQ-016 Access FSM states: IDLE, ACK.
  - IDLE -> ACK when req_i = 1.
  - ACK -> IDLE unconditionally.
  - ack_o = 1 exactly in ACK.
REQ-017 A request shall be sampled only in IDLE, so back-to-back accesses complete at most every 2 cycles and the ack cycle is never re-sampled as a new request.
REQ-018 A write shall commit on the same edge that enters ACK; a read of that register in a following access shall return the new value.
REQ-019 Read data shall be captured on the edge entering ACK. An unmapped read returns 0; an unmapped write has no effect; both are still acknowledged.
REQ-020 in_pad_i shall pass through a 2-flop synchroniser (s1, s2) and then into a history flop (prev); IN reads s2.
REQ-021 Edge event for pin n = (PTRIG[n] ? s2 & ~prev : ~s2 & prev) [n].
REQ-022 INTS[n] shall set on an edge event when INTE[n] = 1; an event with INTE[n] = 0 shall be discarded, not latched.
REQ-023 If a W1C clear and a new event hit the same INTS bit on the same edge, set shall win.
REQ-024 irq_o shall be registered as CTRL[0] & |INTS.
REQ-025 Latency: pad change before edge 0 -> s2 updates at edge 1 -> INTS set at edge 2 -> irq_o high at edge 3.
REQ-026 Writing PTRIG or INTE shall not itself generate an event; events derive only from s2/prev differences.
REQ-027 Clearing CTRL[0] shall drop irq_o on the next edge without altering INTS.

Reset
REQ-028 While rst_n_i = 0, all of the following shall be 0: OUT, OE, INTE, PTRIG, INTS, CTRL, s1, s2, prev, FSM state (IDLE), ack_o, rdata_o, irq_o; all pads are therefore undriven.
REQ-029 Reset asserted while in ACK shall force IDLE and ack_o = 0 immediately.
REQ-030 After reset is released, the first sampled edge with req_i high shall start a new access; a write whose commit edge fell inside reset shall not take effect.
REQ-031 The history flop's reset value of 0 means a pad held high through reset shall produce one rising event after release; this is the defined behaviour.

Verification
REQ-032 Reset, then read all 8 addresses -> every rdata_o = 0x0000_0000, each ack_o a single-cycle pulse, out_pad_o = oen_padoe_o = 0.
REQ-033 Write OE = 0x0000_00FF, then OUT = 0xA5A5_A5A5 -> oen_padoe_o = 0x0000_00FF and out_pad_o = 0xA5A5_A5A5 on the ack edge; read-back matches.
REQ-034 INTE = 0x1, PTRIG = 0x1, CTRL = 0x1, in_pad_i[0] 0->1 before edge 0 -> INTS = 0x1 at edge 2, irq_o = 1 at edge 3; write INTS = 0x1 -> irq_o = 0 one edge after the ack.
REQ-035 PTRIG[3] = 0, INTE[3] = 1, pin 3 falls on the same edge that a W1C of bit 3 commits -> INTS[3] remains 1.
REQ-036 req_i held high continuously for 6 cycles -> ack_o pattern 0,1,0,1,0,1 (three accesses).
REQ-037 Assert rst_n_i during the ACK of a write to OUT -> ack_o = 0 immediately and OUT = 0 after release.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block with pad synchroniser, edge interrupts and a two-state access handshake
module gpio_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ack_o,
  output logic [31:0]      rdata_o,
  input  logic [WIDTH-1:0] in_pad_i,
  output logic [WIDTH-1:0] out_pad_o,
  output logic [WIDTH-1:0] oen_padoe_o,
  output logic             irq_o
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] out_r, oe_r, inte_r, ptrig_r, ints_r, s1, s2, prev, ev, clr;
  logic ctrl_r, take, wr;
  logic [31:0] rd_nx;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    take = state == IDLE && req_i;
    wr = take && we_i;
    state_nx = take ? ACK : IDLE;
    ev = (ptrig_r & s2 & ~prev) | (~ptrig_r & ~s2 & prev);
    clr = (wr && addr_i == 3'd5) ? wdata_i[WIDTH-1:0] : '0;
  end
  always_comb begin
    rd_nx = '0;
    case (addr_i)
      3'd0: rd_nx = 32'(out_r);
      3'd1: rd_nx = 32'(oe_r);
      3'd2: rd_nx = 32'(s2);
      3'd3: rd_nx = 32'(inte_r);
      3'd4: rd_nx = 32'(ptrig_r);
      3'd5: rd_nx = 32'(ints_r);
      3'd6: rd_nx = {31'd0, ctrl_r};
      default: rd_nx = '0;
    endcase
  end
  // A clear and a fresh event on the same bit resolve to set
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      out_r <= '0;
      oe_r <= '0;
      inte_r <= '0;
      ptrig_r <= '0;
      ints_r <= '0;
      ctrl_r <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      rdata_o <= '0;
      irq_o <= 1'b0;
    end else begin
      s1 <= in_pad_i;
      s2 <= s1;
      prev <= s2;
      ints_r <= (ints_r & ~clr) | (ev & inte_r);
      rdata_o <= (take && !we_i) ? rd_nx : '0;
      irq_o <= ctrl_r & |ints_r;
      if (wr)
        case (addr_i)
          3'd0: out_r <= wdata_i[WIDTH-1:0];
          3'd1: oe_r <= wdata_i[WIDTH-1:0];
          3'd3: inte_r <= wdata_i[WIDTH-1:0];
          3'd4: ptrig_r <= wdata_i[WIDTH-1:0];
          3'd6: ctrl_r <= wdata_i[0];
          default: ;
        endcase
    end
  assign ack_o = state == ACK;
  assign out_pad_o = out_r;
  assign oen_padoe_o = oe_r;
endmodule
